// File: rtl/register_file_multiport.sv
// Multi-port register file: combinational reads, two write ports,
// optional zero register and bypass, and a busy scoreboard with live count.
module register_file_multiport #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int READ_PORTS = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_address,
    output logic [READ_PORTS*DATA_WIDTH-1:0] read_data,
    output logic [READ_PORTS-1:0]            read_busy,
    input  logic [1:0]                       write_enabled,
    input  logic [2*ADDR_WIDTH-1:0]          write_address,
    input  logic [2*DATA_WIDTH-1:0]          write_data,
    input  logic                             mark_busy_enabled,
    input  logic [ADDR_WIDTH-1:0]            mark_busy_address,
    output logic [ADDR_WIDTH:0]              busy_count
);
    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam bit LP_ZERO   = (ZERO_REG != 0);
    localparam bit LP_BYPASS = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]      r_busy;
    logic [ADDR_WIDTH:0]   r_busy_count;

    logic [ADDR_WIDTH-1:0] w_wa [2];
    logic [DATA_WIDTH-1:0] w_wd [2];
    logic [1:0]            w_we;
    logic                  w_mark;
    logic [DEPTH-1:0]      w_busy_next;
    logic [ADDR_WIDTH:0]   w_count_next;

    // Writes and marks aimed at the zero register are dropped up front.
    always_comb begin
        for (int j = 0; j < 2; j++) begin
            w_wa[j] = write_address[j*ADDR_WIDTH +: ADDR_WIDTH];
            w_wd[j] = write_data[j*DATA_WIDTH +: DATA_WIDTH];
            w_we[j] = write_enabled[j] && !(LP_ZERO && w_wa[j] == '0);
        end
        w_mark = mark_busy_enabled && !(LP_ZERO && mark_busy_address == '0);
    end

    // Mark is applied after the clears so the newer producer wins.
    always_comb begin
        w_busy_next = r_busy;
        for (int j = 0; j < 2; j++) begin
            if (w_we[j]) begin
                w_busy_next[w_wa[j]] = 1'b0;
            end
        end
        if (w_mark) begin
            w_busy_next[mark_busy_address] = 1'b1;
        end
    end

    always_comb begin
        w_count_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_count_next = w_count_next + (ADDR_WIDTH+1)'(w_busy_next[i]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (w_we[j]) begin
                    r_mem[w_wa[j]] <= w_wd[j];
                end
            end
            r_busy       <= w_busy_next;
            r_busy_count <= w_count_next;
        end
    end

    assign busy_count = r_busy_count;

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_ra;
        logic [DATA_WIDTH-1:0] w_rd;
        logic                  w_rb;

        assign w_ra = read_address[p*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            w_rd = r_mem[w_ra];
            w_rb = r_busy[w_ra];
            if (LP_BYPASS) begin
                for (int j = 0; j < 2; j++) begin
                    if (w_we[j] && w_wa[j] == w_ra) begin
                        w_rd = w_wd[j];
                        w_rb = 1'b0;
                    end
                end
            end
            if ((LP_ZERO && w_ra == '0) || reset) begin
                w_rd = '0;
                w_rb = 1'b0;
            end
        end

        assign read_data[p*DATA_WIDTH +: DATA_WIDTH] = w_rd;
        assign read_busy[p] = w_rb;
    end

endmodule

// File: tb/tb_register_file_multiport.sv
// Bench for register_file_multiport: bypass and non-bypass instances
// share stimulus; directed table, reset sequence and random checks.
module tb_register_file_multiport;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int RP = 2;

    logic           clock = 1'b0;
    logic           reset;
    logic [RP*AW-1:0] read_address;
    logic [1:0]     write_enabled;
    logic [2*AW-1:0] write_address;
    logic [2*DW-1:0] write_data;
    logic           mark_busy_enabled;
    logic [AW-1:0]  mark_busy_address;

    logic [RP*DW-1:0] rd_b, rd_n;
    logic [RP-1:0]    rb_b, rb_n;
    logic [AW:0]      cnt_b, cnt_n;

    register_file_multiport #(.BYPASS(1)) dut (
        .clock(clock), .reset(reset),
        .read_address(read_address), .read_data(rd_b), .read_busy(rb_b),
        .write_enabled(write_enabled), .write_address(write_address),
        .write_data(write_data), .mark_busy_enabled(mark_busy_enabled),
        .mark_busy_address(mark_busy_address), .busy_count(cnt_b)
    );

    register_file_multiport #(.BYPASS(0)) dut_nb (
        .clock(clock), .reset(reset),
        .read_address(read_address), .read_data(rd_n), .read_busy(rb_n),
        .write_enabled(write_enabled), .write_address(write_address),
        .write_data(write_data), .mark_busy_enabled(mark_busy_enabled),
        .mark_busy_address(mark_busy_address), .busy_count(cnt_n)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail = 0;

    logic [DW-1:0] m_mem [32];
    bit            m_busy [32];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW:0] model_read(int a, bit byp);
        logic [DW:0] r;
        r = {m_busy[a], m_mem[a]};
        if (byp) begin
            if (write_enabled[0] && int'(write_address[AW-1:0]) == a)
                r = {1'b0, write_data[DW-1:0]};
            if (write_enabled[1] && int'(write_address[2*AW-1:AW]) == a)
                r = {1'b0, write_data[2*DW-1:DW]};
        end
        if (a == 0 || reset) r = '0;
        return r;
    endfunction

    function automatic int model_count();
        int n = 0;
        foreach (m_busy[i]) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic model_reset();
        foreach (m_mem[i]) begin
            m_mem[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int wa;
        if (!reset) begin
            for (int j = 0; j < 2; j++) begin
                wa = int'(write_address[j*AW +: AW]);
                if (write_enabled[j] && wa != 0) begin
                    m_mem[wa] = write_data[j*DW +: DW];
                    m_busy[wa] = 1'b0;
                end
            end
            if (mark_busy_enabled && mark_busy_address != 0)
                m_busy[int'(mark_busy_address)] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        #1;
    endtask

    task automatic check_all(string tag);
        int a;
        logic [DW:0] e;
        for (int p = 0; p < RP; p++) begin
            a = int'(read_address[p*AW +: AW]);
            e = model_read(a, 1'b1);
            chk($sformatf("%s_byp_rd%0d", tag, p), 64'(rd_b[p*DW +: DW]), 64'(e[DW-1:0]));
            chk($sformatf("%s_byp_rb%0d", tag, p), 64'(rb_b[p]), 64'(e[DW]));
            e = model_read(a, 1'b0);
            chk($sformatf("%s_nb_rd%0d", tag, p), 64'(rd_n[p*DW +: DW]), 64'(e[DW-1:0]));
            chk($sformatf("%s_nb_rb%0d", tag, p), 64'(rb_n[p]), 64'(e[DW]));
        end
        chk({tag, "_cnt_byp"}, 64'(cnt_b), 64'(model_count()));
        chk({tag, "_cnt_nb"}, 64'(cnt_n), 64'(model_count()));
    endtask

    task automatic drive(logic [1:0] we, int wa0, int wa1, logic [31:0] wd0,
                         logic [31:0] wd1, bit mk, int ma, int ra0, int ra1);
        write_enabled     = we;
        write_address     = {AW'(wa1), AW'(wa0)};
        write_data        = {wd1, wd0};
        mark_busy_enabled = mk;
        mark_busy_address = AW'(ma);
        read_address      = {AW'(ra1), AW'(ra0)};
    endtask

    typedef struct {
        logic [1:0]  we;
        int          wa0, wa1;
        logic [31:0] wd0, wd1;
        bit          mk;
        int          ma, ra0, ra1;
        logic [31:0] rd0, rd1;
        bit          rb0, rb1;
        logic [31:0] nb_rd1;
        int          cnt;
    } vec_t;

    vec_t tbl [16];

    initial begin
        tbl[0]  = '{2'b01, 5, 0, 32'hDEADBEEF, 0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0};
        tbl[1]  = '{2'b00, 0, 0, 0, 0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0};
        tbl[2]  = '{2'b11, 7, 7, 32'h11111111, 32'h22222222, 0, 0, 7, 0, 32'h22222222, 0, 0, 0, 0, 0};
        tbl[3]  = '{2'b01, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 7, 0, 32'h22222222, 0, 0, 0, 0, 0};
        tbl[4]  = '{2'b00, 0, 0, 0, 0, 1, 3, 3, 0, 0, 0, 0, 0, 0, 1};
        tbl[5]  = '{2'b00, 0, 0, 0, 0, 1, 4, 3, 4, 0, 0, 1, 0, 0, 2};
        tbl[6]  = '{2'b00, 0, 0, 0, 0, 1, 0, 0, 4, 0, 0, 0, 1, 0, 2};
        tbl[7]  = '{2'b01, 3, 0, 32'h33, 0, 0, 0, 3, 4, 32'h33, 0, 0, 1, 0, 1};
        tbl[8]  = '{2'b00, 0, 0, 0, 0, 0, 0, 3, 4, 32'h33, 0, 0, 1, 0, 1};
        tbl[9]  = '{2'b01, 9, 0, 32'h99, 0, 1, 9, 9, 9, 32'h99, 32'h99, 0, 0, 0, 2};
        tbl[10] = '{2'b00, 0, 0, 0, 0, 0, 0, 9, 9, 32'h99, 32'h99, 1, 1, 32'h99, 2};
        tbl[11] = '{2'b11, 4, 4, 32'h44, 32'h45, 0, 0, 4, 9, 32'h45, 32'h99, 0, 1, 32'h99, 1};
        tbl[12] = '{2'b00, 0, 0, 0, 0, 0, 0, 4, 9, 32'h45, 32'h99, 0, 1, 32'h99, 1};
        tbl[13] = '{2'b01, 4, 0, 32'h4, 0, 1, 10, 10, 4, 0, 32'h4, 0, 0, 32'h45, 2};
        tbl[14] = '{2'b01, 9, 0, 32'h90, 0, 1, 11, 11, 9, 0, 32'h90, 0, 0, 32'h99, 2};
        tbl[15] = '{2'b00, 0, 0, 0, 0, 1, 10, 10, 11, 0, 0, 1, 1, 0, 2};

        model_reset();
        reset = 1'b1;
        drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("reset_cnt", 64'(cnt_b), 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        for (int a = 0; a < 32; a++) begin
            read_address = {AW'(a), AW'(a)};
            #1;
            check_all($sformatf("init_a%0d", a));
        end
        @(negedge clock);
        #1;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].we, tbl[i].wa0, tbl[i].wa1, tbl[i].wd0, tbl[i].wd1,
                  tbl[i].mk, tbl[i].ma, tbl[i].ra0, tbl[i].ra1);
            #1;
            chk($sformatf("v%0d_rd0", i), 64'(rd_b[DW-1:0]), 64'(tbl[i].rd0));
            chk($sformatf("v%0d_rd1", i), 64'(rd_b[2*DW-1:DW]), 64'(tbl[i].rd1));
            chk($sformatf("v%0d_rb0", i), 64'(rb_b[0]), 64'(tbl[i].rb0));
            chk($sformatf("v%0d_rb1", i), 64'(rb_b[1]), 64'(tbl[i].rb1));
            chk($sformatf("v%0d_nb_rd1", i), 64'(rd_n[2*DW-1:DW]), 64'(tbl[i].nb_rd1));
            check_all($sformatf("v%0d", i));
            tick();
            chk($sformatf("v%0d_cnt", i), 64'(cnt_b), 64'(tbl[i].cnt));
        end

        // Async reset pulse between edges with traffic pending.
        for (int a = 1; a <= 6; a++) begin
            drive(2'b00, 0, 0, 0, 0, 1, a, a, 2);
            #1;
            check_all($sformatf("mk%0d", a));
            tick();
        end
        drive(2'b01, 2, 0, 32'h5A, 0, 0, 0, 2, 6);
        #1;
        check_all("w5a");
        tick();
        chk("pre_rst_rd2", 64'(rd_b[DW-1:0]), 64'h5A);
        drive(2'b01, 2, 0, 32'h77, 0, 1, 7, 2, 6);
        reset = 1'b1;
        #1;
        chk("rst_rd_byp", 64'(rd_b), 64'd0);
        chk("rst_rd_nb", 64'(rd_n), 64'd0);
        chk("rst_rb", 64'({rb_b, rb_n}), 64'd0);
        chk("rst_cnt", 64'({cnt_b, cnt_n}), 64'd0);
        drive(2'b00, 0, 0, 0, 0, 0, 0, 2, 6);
        #1;
        reset = 1'b0;
        model_reset();
        tick();
        chk("post_rst_rd2", 64'(rd_b[DW-1:0]), 64'd0);
        chk("post_rst_cnt", 64'(cnt_b), 64'd0);
        check_all("post_rst");

        for (int i = 0; i < 400; i++) begin
            int wa0, wa1, ra0, ra1;
            wa0 = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
            wa1 = ($urandom_range(0, 2) == 0) ? wa0 : int'($urandom_range(0, 7));
            ra0 = ($urandom_range(0, 2) == 0) ? wa0 : int'($urandom_range(0, 31));
            ra1 = ($urandom_range(0, 2) == 0) ? wa1 : int'($urandom_range(0, 7));
            drive(2'($urandom_range(0, 3)), wa0, wa1, $urandom, $urandom,
                  bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)), ra0, ra1);
            #1;
            check_all($sformatf("rnd%0d", i));
            tick();
        end
        drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_all("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/register_file_multiport.md
Name: register_file_multiport

Overview:
Parametrised successor to the single-issue register file. It has DEPTH entries of DATA_WIDTH bits, READ_PORTS combinational read ports and two synchronous write ports. Optional same-cycle write-to-read bypass and an optional hard-wired zero register are provided. A per-entry busy scoreboard with a live busy counter supports the dual-issue pipeline's hazard and stall logic.

Parameters:
DATA_WIDTH, 32, width of each register
ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH
READ_PORTS, 2, number of independent read ports (1..8)
ZERO_REG, 1, when 1 entry 0 always reads 0, ignores writes, never becomes busy
BYPASS, 1, when 1 same-cycle write data and busy-clear are forwarded to reads

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; clears all state
read_address  input  READ_PORTS*ADDR_WIDTH  port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
read_data  output  READ_PORTS*DATA_WIDTH  port i data, packed likewise
read_busy  output  READ_PORTS  busy flag of entry addressed by port i
write_enabled  input  2  per write port enable
write_address  input  2*ADDR_WIDTH  port j at [j*ADDR_WIDTH +: ADDR_WIDTH]
write_data  input  2*DATA_WIDTH  port j at [j*DATA_WIDTH +: DATA_WIDTH]
mark_busy_enabled  input  1  mark an entry busy (new in-flight producer)
mark_busy_address  input  ADDR_WIDTH  entry to mark busy
busy_count  output  ADDR_WIDTH+1  number of entries currently busy

Behaviour:
- Reset, asynchronous and active-high. All entries go to 0, all busy bits to 0, and busy_count to 0 immediately, without waiting for a clock edge. Reset asserted mid-operation discards any pending write or mark in that cycle. While reset is high, read_data is 0 for every address and read_busy is 0.
- Writes take effect at the rising edge of clock when write_enabled[j] is set.
- If both ports write the same address in one cycle, port 1 wins. The entry's busy bit is still cleared.
- When ZERO_REG=1, writes to address 0 are dropped.
- Reads are combinational, and all ports are independent.
- When ZERO_REG=1 and the address is 0, read_data is 0 and read_busy is 0.
- When BYPASS=1 and an enabled write in the current cycle targets the read address:
  - read_data returns that write_data, with port 1 taking priority.
  - read_busy returns 0.
- When BYPASS=0, reads return the stored value; new data is visible the cycle after the edge.
- Scoreboard: a write on port j clears busy[write_address[j]] at the edge.
- mark_busy_enabled sets busy[mark_busy_address] at the edge.
- If a mark and a write hit the same address in the same cycle, the mark wins: the entry ends busy, because the newer producer takes precedence.
- A mark is ignored for address 0 when ZERO_REG=1.
- Marking an entry that is already busy has no effect.
- busy_count is a registered counter and always equals the popcount of the busy bits after each edge.
- Per-edge counter delta = (number of entries going 0->1) - (number of entries going 1->0):
  - Clearing an entry that is not busy does not change the count.
  - Two write ports clearing the same entry decrement the count once.
  - A mark and a clear on different entries in one cycle net to 0.
- busy_count never wraps; its maximum is DEPTH, or DEPTH-1 when ZERO_REG=1.
- Out-of-range parameters, such as READ_PORTS=0, are a configuration error and are not supported.

Test Plan:
- Reset then read all 32 addresses on both ports -> read_data=0 and read_busy=0 everywhere; busy_count=0.
- Write port 0 writes address 5 = 0xDEADBEEF, read port 1 reads address 5 in the same cycle:
  - BYPASS=1 -> 0xDEADBEEF immediately.
  - BYPASS=0 -> old value 0, then 0xDEADBEEF the next cycle.
- Both write ports target address 7 (port 0 = 0x11111111, port 1 = 0x22222222) -> address 7 reads 0x22222222. Writing address 0 = 0xFFFFFFFF with ZERO_REG=1 -> address 0 reads 0.
- Mark addresses 3, 4 and 0 on consecutive cycles -> busy_count goes 1, 2, 2. Then write address 3 on port 0 -> busy_count=1 and read_busy at address 3 = 0.
- In one cycle, mark address 9 and write address 9 -> address 9 is still busy and holds the written data; busy_count rises by 1. Both write ports clearing busy address 4 in one cycle -> busy_count falls by exactly 1.
- Mark addresses 1–6 and write 0x5A to address 2, then pulse reset between clock edges -> all outputs go to 0 immediately; after release, address 2 reads 0 and busy_count=0.
